ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter: RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 inst_addr_o  output  64  fetch address to combinational instruction ROM (word = ROM[addr[13:2]]).
REQ-005 inst_i  input  64  ROM read data, valid in the same cycle as inst_addr_o; instruction = inst_i[31:0].
REQ-006 jump_en_i  input  1  redirect request from execute stage.
REQ-007 jump_addr_i  input  64  redirect target, sampled when jump_en_i=1.
REQ-008 inst_valid_o  output  1  inst_o/inst_pc_o hold a valid instruction.
REQ-009 inst_ready_i  input  1  decode stage accepts the instruction this cycle.
REQ-010 inst_o  output  32  fetched instruction.
REQ-011 inst_pc_o  output  64  address inst_o was fetched from.
REQ-012 fetch_cnt_o  output  64  count of accepted instructions (see Configuration).
REQ-013 redirect_cnt_o  output  32  count of redirects (see Configuration).

Function
REQ-014 inst_addr_o SHALL equal the internal pc register combinationally, with no other logic in the path.
REQ-015 State machine SHALL have two states: BOOT (entered by reset, inst_valid_o=0) and RUN; BOOT -> RUN unconditionally after one cycle, capturing the first instruction at RESET_PC.
REQ-016 In RUN, output slot is "free" when inst_valid_o=0 or (inst_valid_o=1 and inst_ready_i=1).
REQ-017 When free and jump_en_i=0, the block SHALL register inst_o<=inst_i[31:0], inst_pc_o<=pc, inst_valid_o<=1, and pc<=pc+4.
REQ-018 When not free (inst_valid_o=1, inst_ready_i=0) and jump_en_i=0, inst_o, inst_pc_o, inst_valid_o and pc SHALL hold unchanged.
REQ-019 Latency: an instruction at address A is presented on inst_o exactly one cycle after pc=A with the slot free.
REQ-020 Throughput: with inst_ready_i held 1, one instruction per cycle, sequential pc values.
REQ-021 jump_en_i=1 SHALL override every other update, in any state except reset: pc<={jump_addr_i[63:2],2'b00}, inst_valid_o<=0, no capture that cycle.
REQ-022 A handshake (valid and ready) in the same cycle as jump_en_i SHALL still count as consumed; the next instruction presented is from the target.
REQ-023 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 64'h0).
REQ-024 inst_o and inst_pc_o SHALL be stable whenever inst_valid_o=1 and inst_ready_i=0.

Reset
REQ-025 On rst=1 at a clock edge: pc<=RESET_PC, state<=BOOT, inst_valid_o<=0, inst_o<=32'h0, inst_pc_o<=64'h0, both counters<=0.
REQ-026 rst SHALL take priority over jump_en_i and handshakes, including mid-stall; a pending unaccepted instruction is discarded.

Configuration
REQ-027 Macro IFETCH_PERF_CNT_EN: when defined, fetch_cnt_o increments by 1 on each valid&ready cycle and redirect_cnt_o increments by 1 on each jump_en_i=1 cycle, both wrapping modulo 2^width.
REQ-028 When IFETCH_PERF_CNT_EN is undefined, both counter ports SHALL exist and be tied to 0, with no counter registers synthesized.

Verification
REQ-029 Reset release, ready=1, ROM word k = {32'h0, 32'h1000_0000+k} -> cycle 1 inst_pc_o=8000_0000, then 8000_0004, 8000_0008 on consecutive cycles, valid continuous.
REQ-030 Backpressure: ready=0 for 3 cycles at pc 8000_0008 -> inst_o/inst_pc_o frozen, inst_addr_o stays 8000_000C; ready=1 -> 8000_000C next cycle.
REQ-031 Redirect: jump_en_i=1, jump_addr_i=8000_0103 while valid&ready -> next cycle valid=0, inst_addr_o=8000_0100; following cycle inst_pc_o=8000_0100.
REQ-032 Redirect during stall (valid=1, ready=0) -> stalled instruction dropped, valid=0 next cycle, then target instruction.
REQ-033 Wrap: jump to FFFF_FFFF_FFFF_FFFC, ready=1 -> inst_pc_o FFFF_FFFF_FFFF_FFFC then 0.
REQ-034 With IFETCH_PERF_CNT_EN: 10 handshakes, 2 jumps -> fetch_cnt_o=10, redirect_cnt_o=2; mid-run rst -> both 0, inst_valid_o=0 next cycle; without the macro, both read 0 throughout.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch stage: drives a combinational ROM from pc and registers one instruction for decode.
// Latency: an instruction at pc=A appears on inst_o one cycle after pc=A with a free output slot.
// Backpressure: valid/ready; valid=1 with ready=0 freezes inst_o, inst_pc_o and pc. A redirect always wins.
//
// Ports:
//   clk, rst         single clock; synchronous active-high reset
//   inst_addr_o      fetch address to the instruction ROM (direct copy of pc)
//   inst_i           ROM read data for inst_addr_o, same cycle; low 32 bits are the instruction
//   jump_en_i        redirect request from execute
//   jump_addr_i      redirect target, low two bits ignored
//   inst_valid_o     inst_o / inst_pc_o hold a valid instruction
//   inst_ready_i     decode accepts the presented instruction this cycle
//   inst_o           fetched instruction
//   inst_pc_o        address inst_o was fetched from
//   fetch_cnt_o      accepted-instruction count (IFETCH_PERF_CNT_EN), otherwise 0
//   redirect_cnt_o   redirect count (IFETCH_PERF_CNT_EN), otherwise 0
//
// Optional feature macro: IFETCH_PERF_CNT_EN enables the two performance counters.
module ifetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] inst_addr_o,
    input  logic [63:0] inst_i,
    input  logic        jump_en_i,
    input  logic [63:0] jump_addr_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [63:0] inst_pc_o,
    output logic [63:0] fetch_cnt_o,
    output logic [31:0] redirect_cnt_o
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_q,   state_d;
    logic [63:0] pc_q,      pc_d;
    logic        valid_q,   valid_d;
    logic [31:0] inst_q,    inst_d;
    logic [63:0] inst_pc_q, inst_pc_d;

    logic slot_free;
    logic handshake;

    // Upper ROM half and the byte offset of the target are architecturally ignored.
    logic unused_in;
    assign unused_in = ^{inst_i[63:32], jump_addr_i[1:0]};

    // The output slot can take a new instruction when empty or being drained this cycle.
    assign slot_free = !valid_q || inst_ready_i;
    assign handshake = valid_q && inst_ready_i;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;

        if (jump_en_i) begin
            // Redirect beats capture and stall alike; any presented instruction is
            // either consumed by this cycle's handshake or dropped.
            pc_d    = {jump_addr_i[63:2], 2'b00};
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    // Slot is always empty here, so the RESET_PC word is captured.
                    inst_d    = inst_i[31:0];
                    inst_pc_d = pc_q;
                    valid_d   = 1'b1;
                    pc_d      = pc_q + 64'd4;
                    state_d   = ST_RUN;
                end
                ST_RUN: begin
                    if (slot_free) begin
                        inst_d    = inst_i[31:0];
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        // Plain 64-bit add: wraps from ...FFFC to 0.
                        pc_d      = pc_q + 64'd4;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= 64'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign inst_addr_o  = pc_q;
    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [63:0] fetch_cnt_q,    fetch_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        fetch_cnt_d    = fetch_cnt_q + {63'd0, handshake};
        redirect_cnt_d = redirect_cnt_q + {31'd0, jump_en_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q    <= 64'd0;
            redirect_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q    <= fetch_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign fetch_cnt_o    = fetch_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;
`else
    logic unused_hs;
    assign unused_hs = handshake;

    assign fetch_cnt_o    = 64'd0;
    assign redirect_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: vector table plus a counter/reset sequence.
module tb_ifetch;

    logic        clk;
    logic        rst;
    logic [63:0] inst_addr_o;
    logic [63:0] inst_i;
    logic        jump_en_i;
    logic [63:0] jump_addr_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;
    logic [63:0] fetch_cnt_o;
    logic [31:0] redirect_cnt_o;

`ifdef IFETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    ifetch #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_addr_o    (inst_addr_o),
        .inst_i         (inst_i),
        .jump_en_i      (jump_en_i),
        .jump_addr_i    (jump_addr_i),
        .inst_valid_o   (inst_valid_o),
        .inst_ready_i   (inst_ready_i),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .fetch_cnt_o    (fetch_cnt_o),
        .redirect_cnt_o (redirect_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM word k = 32'h1000_0000 + k, k = addr[13:2]
    assign inst_i = {32'h0, 32'h1000_0000 + {20'h0, inst_addr_o[13:2]}};

    typedef struct {
        logic        rst;
        logic        jump;
        logic [63:0] jaddr;
        logic        ready;
        logic        ev;      // expected inst_valid_o after the edge
        logic [63:0] epc;     // expected inst_pc_o
        logic [31:0] einst;   // expected inst_o
        logic [63:0] eaddr;   // expected inst_addr_o
        logic        chk_dat; // compare inst_o / inst_pc_o
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic r, input logic j, input logic [63:0] ja,
                                input logic rd, input logic ev, input logic [63:0] ep,
                                input logic [31:0] ei, input logic [63:0] ea, input logic cd);
        vec_t v;
        v.rst = r; v.jump = j; v.jaddr = ja; v.ready = rd;
        v.ev = ev; v.epc = ep; v.einst = ei; v.eaddr = ea; v.chk_dat = cd;
        return v;
    endfunction

    logic [63:0] m_fetch;
    logic [31:0] m_redir;
    logic        prev_valid;

    initial begin
        rst          = 1'b1;
        jump_en_i    = 1'b0;
        jump_addr_i  = 64'h0;
        inst_ready_i = 1'b1;
        m_fetch      = 64'd0;
        m_redir      = 32'd0;
        prev_valid   = 1'b0;

        //            rst  jmp  jaddr                   rdy  ev   inst_pc                 inst           inst_addr               chk
        vecs[0]  = mk(1'b1,1'b0,64'h0,                  1'b1,1'b0,64'h0,                  32'h0,         64'h0000_0000_8000_0000,1'b1);
        vecs[1]  = mk(1'b1,1'b0,64'h0,                  1'b1,1'b0,64'h0,                  32'h0,         64'h0000_0000_8000_0000,1'b1);
        vecs[2]  = mk(1'b0,1'b0,64'h0,                  1'b1,1'b1,64'h0000_0000_8000_0000,32'h1000_0000,64'h0000_0000_8000_0004,1'b1);
        vecs[3]  = mk(1'b0,1'b0,64'h0,                  1'b1,1'b1,64'h0000_0000_8000_0004,32'h1000_0001,64'h0000_0000_8000_0008,1'b1);
        vecs[4]  = mk(1'b0,1'b0,64'h0,                  1'b1,1'b1,64'h0000_0000_8000_0008,32'h1000_0002,64'h0000_0000_8000_000C,1'b1);
        vecs[5]  = mk(1'b0,1'b0,64'h0,                  1'b0,1'b1,64'h0000_0000_8000_0008,32'h1000_0002,64'h0000_0000_8000_000C,1'b1);
        vecs[6]  = mk(1'b0,1'b0,64'h0,                  1'b0,1'b1,64'h0000_0000_8000_0008,32'h1000_0002,64'h0000_0000_8000_000C,1'b1);
        vecs[7]  = mk(1'b0,1'b0,64'h0,                  1'b0,1'b1,64'h0000_0000_8000_0008,32'h1000_0002,64'h0000_0000_8000_000C,1'b1);
        vecs[8]  = mk(1'b0,1'b0,64'h0,                  1'b1,1'b1,64'h0000_0000_8000_000C,32'h1000_0003,64'h0000_0000_8000_0010,1'b1);
        vecs[9]  = mk(1'b0,1'b1,64'h0000_0000_8000_0103,1'b1,1'b0,64'h0,                  32'h0,         64'h0000_0000_8000_0100,1'b0);
        vecs[10] = mk(1'b0,1'b0,64'h0,                  1'b1,1'b1,64'h0000_0000_8000_0100,32'h1000_0040,64'h0000_0000_8000_0104,1'b1);
        vecs[11] = mk(1'b0,1'b0,64'h0,                  1'b0,1'b1,64'h0000_0000_8000_0100,32'h1000_0040,64'h0000_0000_8000_0104,1'b1);
        vecs[12] = mk(1'b0,1'b1,64'h0000_0000_8000_0200,1'b0,1'b0,64'h0,                  32'h0,         64'h0000_0000_8000_0200,1'b0);
        vecs[13] = mk(1'b0,1'b0,64'h0,                  1'b0,1'b1,64'h0000_0000_8000_0200,32'h1000_0080,64'h0000_0000_8000_0204,1'b1);
        vecs[14] = mk(1'b0,1'b1,64'hFFFF_FFFF_FFFF_FFFC,1'b1,1'b0,64'h0,                  32'h0,         64'hFFFF_FFFF_FFFF_FFFC,1'b0);
        vecs[15] = mk(1'b0,1'b0,64'h0,                  1'b1,1'b1,64'hFFFF_FFFF_FFFF_FFFC,32'h1000_0FFF,64'h0,                  1'b1);
        vecs[16] = mk(1'b0,1'b0,64'h0,                  1'b1,1'b1,64'h0,                  32'h1000_0000,64'h4,                  1'b1);
        vecs[17] = mk(1'b0,1'b0,64'h0,                  1'b1,1'b1,64'h4,                  32'h1000_0001,64'h8,                  1'b1);
        vecs[18] = mk(1'b1,1'b1,64'h0000_0000_8000_0400,1'b0,1'b0,64'h0,                  32'h0,         64'h0000_0000_8000_0000,1'b1);
        vecs[19] = mk(1'b0,1'b0,64'h0,                  1'b1,1'b1,64'h0000_0000_8000_0000,32'h1000_0000,64'h0000_0000_8000_0004,1'b1);
        vecs[20] = mk(1'b1,1'b0,64'h0,                  1'b1,1'b0,64'h0,                  32'h0,         64'h0000_0000_8000_0000,1'b1);
        vecs[21] = mk(1'b0,1'b1,64'h0000_0000_8000_0010,1'b1,1'b0,64'h0,                  32'h0,         64'h0000_0000_8000_0010,1'b0);
        vecs[22] = mk(1'b0,1'b0,64'h0,                  1'b1,1'b1,64'h0000_0000_8000_0010,32'h1000_0004,64'h0000_0000_8000_0014,1'b1);

        for (int i = 0; i < NV; i++) begin
            rst          = vecs[i].rst;
            jump_en_i    = vecs[i].jump;
            jump_addr_i  = vecs[i].jaddr;
            inst_ready_i = vecs[i].ready;
            if (vecs[i].rst) begin
                m_fetch = 64'd0;
                m_redir = 32'd0;
            end else begin
                if (prev_valid && vecs[i].ready) m_fetch = m_fetch + 64'd1;
                if (vecs[i].jump) m_redir = m_redir + 32'd1;
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d valid", i), {63'd0, inst_valid_o}, {63'd0, vecs[i].ev});
            check($sformatf("v%0d addr", i), inst_addr_o, vecs[i].eaddr);
            if (vecs[i].chk_dat) begin
                check($sformatf("v%0d inst_pc", i), inst_pc_o, vecs[i].epc);
                check($sformatf("v%0d inst", i), {32'd0, inst_o}, {32'd0, vecs[i].einst});
            end
            check($sformatf("v%0d fetch_cnt", i), fetch_cnt_o, PERF ? m_fetch : 64'd0);
            check($sformatf("v%0d redirect_cnt", i), {32'd0, redirect_cnt_o}, PERF ? {32'd0, m_redir} : 64'd0);
            prev_valid = vecs[i].ev;
        end

        // Counter sequence: 10 handshakes, 2 jumps, then reset mid-run.
        rst = 1'b1; jump_en_i = 1'b0; inst_ready_i = 1'b1;
        @(posedge clk); #1;
        check("seq reset valid", {63'd0, inst_valid_o}, 64'd0);
        check("seq reset fetch_cnt", fetch_cnt_o, 64'd0);
        rst = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        check("seq fetch_cnt 10", fetch_cnt_o, PERF ? 64'd10 : 64'd0);
        check("seq inst_pc after 11", inst_pc_o, 64'h0000_0000_8000_0028);
        inst_ready_i = 1'b0; jump_en_i = 1'b1; jump_addr_i = 64'h0000_0000_8000_0300;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("seq redirect_cnt 2", {32'd0, redirect_cnt_o}, PERF ? 64'd2 : 64'd0);
        check("seq fetch_cnt hold", fetch_cnt_o, PERF ? 64'd10 : 64'd0);
        check("seq jump valid", {63'd0, inst_valid_o}, 64'd0);
        check("seq jump addr", inst_addr_o, 64'h0000_0000_8000_0300);
        jump_en_i = 1'b0;
        @(posedge clk); #1;
        check("seq target pc", inst_pc_o, 64'h0000_0000_8000_0300);
        check("seq target valid", {63'd0, inst_valid_o}, 64'd1);
        @(posedge clk); #1;
        check("seq stall fetch_cnt", fetch_cnt_o, PERF ? 64'd10 : 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("seq midrun rst valid", {63'd0, inst_valid_o}, 64'd0);
        check("seq midrun rst fetch_cnt", fetch_cnt_o, 64'd0);
        check("seq midrun rst redirect_cnt", {32'd0, redirect_cnt_o}, 64'd0);
        check("seq midrun rst addr", inst_addr_o, 64'h0000_0000_8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
